// File: rtl/cpu_mon_pkg.sv
// Shared types and constants for the pipeline commit monitor.
// State encoding, default halt sentinel, trace-entry layout and drop-counter width.
package cpu_mon_pkg;

  localparam int MON_DATA_W = 32;
  localparam int MON_REG_AW = 5;
  localparam int DROP_W     = 16;

  localparam logic [MON_DATA_W-1:0] HALT_INSTR_DEFAULT = 32'h0000000C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [MON_DATA_W-1:0] pc;
    logic [MON_DATA_W-1:0] instr;
    logic [MON_REG_AW-1:0] reg_num;
    logic [MON_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/mon_sync_fifo.sv
// Synchronous FIFO holding retirement trace entries.
// Extra pointer bit separates full from empty; a push while full is taken only
// when a pop frees the head slot in the same cycle. Storage is not reset.
module mon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop; wraps naturally modulo 2*DEPTH
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; written slot becomes visible at the head one cycle later
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pipeline_commit_monitor.sv
// Retirement monitor for the pipelined MIPS core: taps WB, counts cycles and
// retirements, buffers GPR writes in a trace FIFO and detects halt from the
// syscall sentinel or a branch-to-self loop.
// Build option: define TRACE_ALL_EN to trace every retirement (non-writing or
// $0-writing entries carry reg_num=0, data=0); default traces only GPR writes
// to nonzero registers.
module pipeline_commit_monitor
  import cpu_mon_pkg::*;
#(
  parameter int                DATA_W      = MON_DATA_W,
  parameter int                REG_AW      = MON_REG_AW,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                HALT_REPEAT = 4,
  parameter logic [DATA_W-1:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [DATA_W-1:0] wb_instr,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_reg_num,
  input  logic [DATA_W-1:0] wb_reg_data,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [DATA_W-1:0] trace_pc,
  output logic [DATA_W-1:0] trace_instr,
  output logic [REG_AW-1:0] trace_reg_num,
  output logic [DATA_W-1:0] trace_data,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retire_count,
  output logic [DROP_W-1:0] drop_count,
  output logic              halted,
  output logic [1:0]        state
);

  localparam int RPT_W = $clog2(HALT_REPEAT + 1);

  mon_state_e       state_q;
  mon_state_e       state_d;

  logic             in_run;
  logic             run_retire;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  trace_entry_t     push_entry;
  trace_entry_t     head_entry;

  logic             rpt_have;
  logic [DATA_W-1:0] rpt_pc;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_next;
  logic             halt_hit;

  assign in_run     = (state_q == ST_RUN);
  assign run_retire = in_run && wb_valid;
  assign pop        = trace_valid && trace_ready;

`ifdef TRACE_ALL_EN
  logic gpr_write;
  assign gpr_write          = wb_reg_write && (wb_reg_num != '0);
  assign push_req           = run_retire;
  assign push_entry.pc      = wb_pc;
  assign push_entry.instr   = wb_instr;
  assign push_entry.reg_num = gpr_write ? wb_reg_num  : '0;
  assign push_entry.data    = gpr_write ? wb_reg_data : '0;
`else
  assign push_req           = run_retire && wb_reg_write && (wb_reg_num != '0);
  assign push_entry.pc      = wb_pc;
  assign push_entry.instr   = wb_instr;
  assign push_entry.reg_num = wb_reg_num;
  assign push_entry.data    = wb_reg_data;
`endif

  mon_sync_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign trace_valid   = !fifo_empty;
  assign trace_pc      = head_entry.pc;
  assign trace_instr   = head_entry.instr;
  assign trace_reg_num = head_entry.reg_num;
  assign trace_data    = head_entry.data;

  // Length of the current same-PC retirement run, including this retirement;
  // saturates at HALT_REPEAT so it never wraps during long bubbles of repeats
  always_comb begin
    rpt_next = RPT_W'(1);
    if (rpt_have && (wb_pc == rpt_pc)) begin
      rpt_next = (rpt_cnt == RPT_W'(HALT_REPEAT)) ? rpt_cnt : rpt_cnt + 1'b1;
    end
  end

  assign halt_hit = run_retire &&
                    ((wb_instr == HALT_INSTR) || (rpt_next == RPT_W'(HALT_REPEAT)));

  // Repeat-run control: only valid retirements in RUN update the run
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_have <= 1'b0;
      rpt_cnt  <= '0;
    end else if (run_retire) begin
      rpt_have <= 1'b1;
      rpt_cnt  <= rpt_next;
    end
  end

  // Last retired PC; qualified by rpt_have so it needs no reset
  always_ff @(posedge clock) begin
    if (run_retire) rpt_pc <= wb_pc;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE waits for enable, RUN until halt, DRAIN until empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable)     state_d = ST_RUN;
      ST_RUN:   if (halt_hit)   state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Cycle/retirement/drop counters; all frozen outside RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count  <= '0;
      retire_count <= '0;
      drop_count   <= '0;
    end else if (in_run) begin
      cycle_count <= cycle_count + 1'b1;
      if (wb_valid) retire_count <= retire_count + 1'b1;
      if (push_req && fifo_full && !pop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign halted = (state_q == ST_DONE);
  assign state  = state_q;

endmodule

// File: tb/tb_pipeline_commit_monitor.sv
// Directed bench for pipeline_commit_monitor: trace ordering, FIFO overflow and
// full push/pop, halt by sentinel and self-loop, reset mid-DRAIN, trace-all option.
module tb_pipeline_commit_monitor;

`ifdef TRACE_ALL_EN
  localparam int TA = 1;
`else
  localparam int TA = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_num;
  logic [31:0] wb_reg_data;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [4:0]  trace_reg_num;
  logic [31:0] trace_data;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
  logic [15:0] drop_count;
  logic        halted;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipeline_commit_monitor dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_instr      (wb_instr),
    .wb_reg_write  (wb_reg_write),
    .wb_reg_num    (wb_reg_num),
    .wb_reg_data   (wb_reg_data),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_pc      (trace_pc),
    .trace_instr   (trace_instr),
    .trace_reg_num (trace_reg_num),
    .trace_data    (trace_data),
    .cycle_count   (cycle_count),
    .retire_count  (retire_count),
    .drop_count    (drop_count),
    .halted        (halted),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                        input logic [4:0] rn, input logic [31:0] d);
    wb_valid     = 1'b1;
    wb_pc        = pc;
    wb_instr     = instr;
    wb_reg_write = rw;
    wb_reg_num   = rn;
    wb_reg_data  = d;
    step();
    wb_valid     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_instr = '0;
    wb_reg_write = 1'b0; wb_reg_num = '0; wb_reg_data = '0; trace_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(trace_valid), 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    enable = 1'b1; step(); enable = 1'b0;
    chk("run_state", 32'(state), 32'd1);
    chk("run_cycle0", cycle_count, 32'd0);

    // three retirements, $0 write not traced
    trace_ready = 1'b1;
    retire(32'h100, 32'h01, 1'b1, 5'd8, 32'h11);
    chk("t1_valid1", 32'(trace_valid), 32'd1);
    chk("t1_pc1", trace_pc, 32'h100);
    chk("t1_reg1", 32'(trace_reg_num), 32'd8);
    chk("t1_data1", trace_data, 32'h11);
    retire(32'h104, 32'h01, 1'b1, 5'd9, 32'h22);
    chk("t1_valid2", 32'(trace_valid), 32'd1);
    chk("t1_reg2", 32'(trace_reg_num), 32'd9);
    chk("t1_data2", trace_data, 32'h22);
    retire(32'h108, 32'h01, 1'b1, 5'd0, 32'h33);
`ifdef TRACE_ALL_EN
    chk("t1_valid3", 32'(trace_valid), 32'd1);
    chk("t1_reg3", 32'(trace_reg_num), 32'd0);
    chk("t1_data3", trace_data, 32'd0);
`else
    chk("t1_valid3", 32'(trace_valid), 32'd0);
`endif
    chk("t1_retire", retire_count, 32'd3);
    chk("t1_cycle", cycle_count, 32'd3);
    if (TA != 0) step();

    // overflow: 20 pushes into 16 slots
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) retire(32'h200 + 32'(4 * i), 32'h01, 1'b1, 5'd10, 32'(i));
    chk("t2_drop", 32'(drop_count), 32'd4);
    chk("t2_valid", 32'(trace_valid), 32'd1);
    chk("t2_head", trace_data, 32'd0);
    chk("t2_cycle", cycle_count, 32'(23 + TA));
    chk("t2_retire", retire_count, 32'd23);
    trace_ready = 1'b1;
    retire(32'h300, 32'h01, 1'b1, 5'd11, 32'hAA);
    chk("t2_fullpp_drop", 32'(drop_count), 32'd4);
    chk("t2_fullpp_head", trace_data, 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk("t2_drain", trace_data, 32'(i));
      step();
    end
    chk("t2_last", trace_data, 32'hAA);
    step();
    chk("t2_empty", 32'(trace_valid), 32'd0);
    chk("t2_cycle_end", cycle_count, 32'(40 + TA));

    // sentinel halt with two entries pending
    trace_ready = 1'b0;
    retire(32'h400, 32'h01, 1'b1, 5'd12, 32'h55);
    retire(32'h404, 32'h01, 1'b1, 5'd13, 32'h66);
    trace_ready = 1'b1;
    retire(32'h40, 32'h0000000C, 1'b0, 5'd0, 32'd0);
    chk("t3_drain", 32'(state), 32'd2);
    chk("t3_head", trace_data, 32'h66);
    step();
    if (TA != 0) step();
    chk("t3_drain2", 32'(state), 32'd2);
    chk("t3_empty", 32'(trace_valid), 32'd0);
    step();
    chk("t3_done", 32'(state), 32'd3);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_cycle", cycle_count, 32'(43 + TA));
    chk("t3_retire", retire_count, 32'd27);
    retire(32'h44, 32'h01, 1'b1, 5'd3, 32'h9);
    chk("t3_frz_retire", retire_count, 32'd27);
    chk("t3_frz_cycle", cycle_count, 32'(43 + TA));
    chk("t3_frz_valid", 32'(trace_valid), 32'd0);
    enable = 1'b1; step(); enable = 1'b0;
    chk("t3_en_ignored", 32'(state), 32'd3);

    // self-loop halt with bubbles
    reset = 1'b1; step(); reset = 1'b0;
    enable = 1'b1; step(); enable = 1'b0;
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0); step();
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0); step();
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0); step();
    chk("t4_no_halt3", 32'(state), 32'd1);
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0);
    chk("t4_halt4", 32'(state), 32'd2);
    chk("t4_retire", retire_count, 32'd4);
    chk("t4_cycle", cycle_count, 32'd7);
    if (TA != 0) step();
    step();
    chk("t4_done", 32'(state), 32'd3);

    // broken run does not halt
    reset = 1'b1; step(); reset = 1'b0;
    enable = 1'b1; step(); enable = 1'b0;
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0);
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0);
    retire(32'h20, 32'h02, 1'b0, 5'd0, 32'd0);
    retire(32'h1C, 32'h02, 1'b0, 5'd0, 32'd0);
    chk("t4b_run", 32'(state), 32'd1);
    chk("t4b_retire", retire_count, 32'd4);

    // reset in DRAIN with entries pending
    trace_ready = 1'b0;
    retire(32'h500, 32'h01, 1'b1, 5'd14, 32'd1);
    retire(32'h504, 32'h0000000C, 1'b1, 5'd15, 32'd2);
    chk("t5_drain", 32'(state), 32'd2);
    chk("t5_pending", 32'(trace_valid), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_valid", 32'(trace_valid), 32'd0);
    chk("t5_cycle", cycle_count, 32'd0);
    chk("t5_retire", retire_count, 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd0);
    chk("t5_halted", 32'(halted), 32'd0);

    // store (no GPR write)
    enable = 1'b1; step(); enable = 1'b0;
    retire(32'h08, 32'hAC050000, 1'b0, 5'd5, 32'h77);
`ifdef TRACE_ALL_EN
    chk("t6_valid", 32'(trace_valid), 32'd1);
    chk("t6_pc", trace_pc, 32'h08);
    chk("t6_reg", 32'(trace_reg_num), 32'd0);
    chk("t6_data", trace_data, 32'd0);
`else
    chk("t6_valid", 32'(trace_valid), 32'd0);
`endif
    chk("t6_retire", retire_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
